// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the MEM stage (master) and the data memory / bus bridge (slave).
// Request/ack handshake: the master holds every request field stable until ack.
interface mem_access_unit_if;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;

    modport master (
        output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
        input  dbus_ack_i, dbus_rdata_i
    );

    modport slave (
        input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
        output dbus_ack_i, dbus_rdata_i
    );
endinterface

// File: rtl/mem_access_unit.sv
// MiniMIPS32 MEM stage: alignment check, byte-lane bus transaction, load extension.
// Stall = 2 + bus wait cycles per access; misaligned/excepted ops never touch the bus.
module mem_access_unit (
    input  logic                     cpu_clk_50M,
    input  logic                     cpu_rst,
    input  logic                     mem_valid_i,
    input  logic [7:0]               mem_aluop_i,
    input  logic [31:0]              mem_addr_i,
    input  logic [31:0]              mem_din_i,
    input  logic [4:0]               mem_exccode_i,
    input  logic                     flush_i,
    mem_access_unit_if.master        dbus,
    output logic [31:0]              load_data_o,
    output logic                     load_valid_o,
    output logic [4:0]               mem_exccode_o,
    output logic [31:0]              badvaddr_o,
    output logic                     stallreq_mem
);

    localparam logic [7:0] MINIMIPS32_LB  = 8'h90;
    localparam logic [7:0] MINIMIPS32_LBU = 8'h91;
    localparam logic [7:0] MINIMIPS32_LH  = 8'h92;
    localparam logic [7:0] MINIMIPS32_LHU = 8'h93;
    localparam logic [7:0] MINIMIPS32_LW  = 8'h94;
    localparam logic [7:0] MINIMIPS32_SB  = 8'h98;
    localparam logic [7:0] MINIMIPS32_SH  = 8'h99;
    localparam logic [7:0] MINIMIPS32_SW  = 8'h9A;

    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_NONE = 5'h10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        is_load;
    logic        is_store;
    logic        misalign;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        exc_in_none;
    logic        start;

    logic [7:0]  op_q;
    logic [1:0]  lane_q;
    logic        flushed_q;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_ext;

    // Opcode decode: width-dependent alignment rule, lane mask and replicated store data.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misalign = 1'b0;
        be_c     = 4'b0000;
        wdata_c  = 32'h0;
        case (mem_aluop_i)
            MINIMIPS32_LB, MINIMIPS32_LBU: begin
                is_load = 1'b1;
                be_c    = 4'b0001 << mem_addr_i[1:0];
            end
            MINIMIPS32_LH, MINIMIPS32_LHU: begin
                is_load  = 1'b1;
                misalign = mem_addr_i[0];
                be_c     = mem_addr_i[1] ? 4'b1100 : 4'b0011;
            end
            MINIMIPS32_LW: begin
                is_load  = 1'b1;
                misalign = |mem_addr_i[1:0];
                be_c     = 4'b1111;
            end
            MINIMIPS32_SB: begin
                is_store = 1'b1;
                be_c     = 4'b0001 << mem_addr_i[1:0];
                wdata_c  = {4{mem_din_i[7:0]}};
            end
            MINIMIPS32_SH: begin
                is_store = 1'b1;
                misalign = mem_addr_i[0];
                be_c     = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_c  = {2{mem_din_i[15:0]}};
            end
            MINIMIPS32_SW: begin
                is_store = 1'b1;
                misalign = |mem_addr_i[1:0];
                be_c     = 4'b1111;
                wdata_c  = mem_din_i;
            end
            default: ;
        endcase
    end

    assign exc_in_none = (mem_exccode_i == EXC_NONE);
    assign start = mem_valid_i & (is_load | is_store) & exc_in_none & ~misalign & ~flush_i;

    // An exception from an earlier stage outranks the address fault.
    always_comb begin
        mem_exccode_o = mem_exccode_i;
        badvaddr_o    = 32'h0;
        if (exc_in_none && misalign) begin
            mem_exccode_o = is_load ? EXC_ADEL : EXC_ADES;
            badvaddr_o    = mem_addr_i;
        end
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = REQ;
            REQ:  if (dbus.dbus_ack_i) state_d = (flush_i | flushed_q) ? IDLE : DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stallreq_mem = 1'b0;
        load_valid_o = 1'b0;
        case (state_q)
            IDLE: stallreq_mem = start;
            REQ:  stallreq_mem = 1'b1;
            DONE: load_valid_o = ~dbus.dbus_we_o;
            default: ;
        endcase
    end

    assign byte_v = dbus.dbus_rdata_i[{lane_q, 3'b000} +: 8];
    assign half_v = lane_q[1] ? dbus.dbus_rdata_i[31:16] : dbus.dbus_rdata_i[15:0];

    always_comb begin
        load_ext = dbus.dbus_rdata_i;
        case (op_q)
            MINIMIPS32_LB:  load_ext = {{24{byte_v[7]}}, byte_v};
            MINIMIPS32_LBU: load_ext = {24'h0, byte_v};
            MINIMIPS32_LH:  load_ext = {{16{half_v[15]}}, half_v};
            MINIMIPS32_LHU: load_ext = {16'h0, half_v};
            default: ;
        endcase
    end

    // Bus fields are captured once at issue and held until the edge that sees ack.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            dbus.dbus_req_o   <= 1'b0;
            dbus.dbus_we_o    <= 1'b0;
            dbus.dbus_addr_o  <= 32'h0;
            dbus.dbus_be_o    <= 4'b0000;
            dbus.dbus_wdata_o <= 32'h0;
            load_data_o       <= 32'h0;
            op_q              <= 8'h0;
            lane_q            <= 2'b00;
            flushed_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dbus.dbus_req_o   <= 1'b1;
                        dbus.dbus_we_o    <= is_store;
                        dbus.dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        dbus.dbus_be_o    <= be_c;
                        dbus.dbus_wdata_o <= wdata_c;
                        op_q              <= mem_aluop_i;
                        lane_q            <= mem_addr_i[1:0];
                        flushed_q         <= 1'b0;
                    end
                end
                REQ: begin
                    if (flush_i) flushed_q <= 1'b1;
                    if (dbus.dbus_ack_i) begin
                        dbus.dbus_req_o <= 1'b0;
                        if (!dbus.dbus_we_o) load_data_o <= load_ext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a transaction-level byte-lane model.
module tb_mem_access_unit;

    localparam logic [7:0] OP_LB  = 8'h90;
    localparam logic [7:0] OP_LBU = 8'h91;
    localparam logic [7:0] OP_LH  = 8'h92;
    localparam logic [7:0] OP_LHU = 8'h93;
    localparam logic [7:0] OP_LW  = 8'h94;
    localparam logic [7:0] OP_SB  = 8'h98;
    localparam logic [7:0] OP_SH  = 8'h99;
    localparam logic [7:0] OP_SW  = 8'h9A;
    localparam logic [7:0] OP_ADD = 8'h18;

    localparam logic [4:0] EXC_OV   = 5'h0C;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_NONE = 5'h10;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst;
    logic        mem_valid_i;
    logic [7:0]  mem_aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_din_i;
    logic [4:0]  mem_exccode_i;
    logic        flush_i;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic [4:0]  mem_exccode_o;
    logic [31:0] badvaddr_o;
    logic        stallreq_mem;

    int n_chk  = 0;
    int n_pass = 0;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .cpu_clk_50M   (cpu_clk_50M),
        .cpu_rst       (cpu_rst),
        .mem_valid_i   (mem_valid_i),
        .mem_aluop_i   (mem_aluop_i),
        .mem_addr_i    (mem_addr_i),
        .mem_din_i     (mem_din_i),
        .mem_exccode_i (mem_exccode_i),
        .flush_i       (flush_i),
        .dbus          (bus),
        .load_data_o   (load_data_o),
        .load_valid_o  (load_valid_o),
        .mem_exccode_o (mem_exccode_o),
        .badvaddr_o    (badvaddr_o),
        .stallreq_mem  (stallreq_mem)
    );

    always #10 cpu_clk_50M = ~cpu_clk_50M;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        else n_pass++;
    endtask

    // Reference model: access described by its width in bytes and offset in the word.
    function automatic int op_size(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit op_is_store(input logic [7:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic bit op_is_signed(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int unsigned sz = op_size(op);
        longint unsigned mask = (64'd1 << (8 * sz)) - 1;
        longint unsigned v = (64'(rdata) >> (8 * (addr % 4))) & mask;
        if (op_is_signed(op) && v >= (mask + 1) / 2) v = v + 64'hFFFF_FFFF - mask;
        return v[31:0];
    endfunction

    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] din,
                          input logic [4:0] exc, input bit flush_idle, input int nwait,
                          input int flush_at, input logic [31:0] rdata);
        int sz = op_size(op);
        bit st = op_is_store(op);
        bit misal = (sz != 0) && ((addr % sz) != 0);
        bit fault = (exc == EXC_NONE) && misal;
        bit started = (sz != 0) && (exc == EXC_NONE) && !misal && !flush_idle;
        logic [4:0] e_exc = fault ? (st ? EXC_ADES : EXC_ADEL) : exc;
        logic [3:0] e_be = 4'(((1 << sz) - 1) << (addr % 4));
        logic [31:0] e_wd = !st ? 32'h0 : (sz == 1) ? din[7:0] * 32'h0101_0101 :
                            (sz == 2) ? din[15:0] * 32'h0001_0001 : din;
        int stalls = 0;
        bit flushed = 0;

        @(negedge cpu_clk_50M);
        mem_valid_i = 1'b1; mem_aluop_i = op; mem_addr_i = addr; mem_din_i = din;
        mem_exccode_i = exc; flush_i = flush_idle; bus.dbus_ack_i = 1'b0;
        bus.dbus_rdata_i = $urandom;
        #1;
        chk("exccode", 32'(mem_exccode_o), 32'(e_exc));
        chk("badvaddr", badvaddr_o, fault ? addr : 32'h0);
        chk("stall_c0", 32'(stallreq_mem), 32'(started));
        chk("req_idle", 32'(bus.dbus_req_o), 32'h0);
        stalls += int'(stallreq_mem);
        if (!started) begin
            @(negedge cpu_clk_50M);
            flush_i = 1'b0;
            #1;
            chk("no_req", 32'(bus.dbus_req_o), 32'h0);
            chk("no_lvalid", 32'(load_valid_o), 32'h0);
            mem_valid_i = 1'b0;
            return;
        end
        flush_i = 1'b0;
        for (int w = 0; w <= nwait; w++) begin
            @(negedge cpu_clk_50M);
            flush_i = (w == flush_at);
            if (w == flush_at) flushed = 1;
            bus.dbus_ack_i = (w == nwait);
            bus.dbus_rdata_i = (w == nwait) ? rdata : $urandom;
            #1;
            chk("req", 32'(bus.dbus_req_o), 32'h1);
            chk("we", 32'(bus.dbus_we_o), 32'(st));
            chk("addr", bus.dbus_addr_o, addr & 32'hFFFF_FFFC);
            chk("be", 32'(bus.dbus_be_o), 32'(e_be));
            chk("wdata", bus.dbus_wdata_o, e_wd);
            stalls += int'(stallreq_mem);
        end
        @(negedge cpu_clk_50M);
        flush_i = 1'b0; bus.dbus_ack_i = 1'b0;
        if (flushed) mem_valid_i = 1'b0;
        #1;
        chk("stall_end", 32'(stallreq_mem), 32'h0);
        chk("req_dropped", 32'(bus.dbus_req_o), 32'h0);
        chk("lvalid", 32'(load_valid_o), 32'(!st && !flushed));
        if (!st && !flushed) chk("ldata", load_data_o, model_load(op, addr, rdata));
        chk("stall_cycles", 32'(stalls), 32'(2 + nwait));
        mem_valid_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(bus.dbus_req_o), 32'h0);
        chk({tag, "_we"}, 32'(bus.dbus_we_o), 32'h0);
        chk({tag, "_addr"}, bus.dbus_addr_o, 32'h0);
        chk({tag, "_be"}, 32'(bus.dbus_be_o), 32'h0);
        chk({tag, "_wdata"}, bus.dbus_wdata_o, 32'h0);
        chk({tag, "_ldata"}, load_data_o, 32'h0);
        chk({tag, "_lvalid"}, 32'(load_valid_o), 32'h0);
        chk({tag, "_stall"}, 32'(stallreq_mem), 32'h0);
    endtask

    logic [7:0] op_tab [9] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_ADD};

    initial begin
        cpu_rst = 1'b1; mem_valid_i = 1'b0; mem_aluop_i = 8'h0; mem_addr_i = 32'h0;
        mem_din_i = 32'h0; mem_exccode_i = EXC_NONE; flush_i = 1'b0;
        bus.dbus_ack_i = 1'b0; bus.dbus_rdata_i = 32'h0;
        repeat (2) @(negedge cpu_clk_50M);
        #1;
        check_reset_outputs("reset");
        @(negedge cpu_clk_50M);
        cpu_rst = 1'b0;

        run_op(OP_LW,  32'h1000_0008, 32'h0, EXC_NONE, 0, 0, -1, 32'hDEAD_BEEF);
        run_op(OP_LB,  32'h1000_0003, 32'h0, EXC_NONE, 0, 0, -1, 32'h8011_2233);
        run_op(OP_LBU, 32'h1000_0003, 32'h0, EXC_NONE, 0, 0, -1, 32'h8011_2233);
        run_op(OP_SH,  32'h1000_0002, 32'h0000_ABCD, EXC_NONE, 0, 3, -1, 32'h0);
        run_op(OP_LW,  32'h1000_0001, 32'h0, EXC_NONE, 0, 0, -1, 32'h0);
        run_op(OP_SW,  32'h1000_0004, 32'h1234_5678, EXC_OV, 0, 0, -1, 32'h0);
        run_op(OP_LW,  32'h1000_0010, 32'h0, EXC_NONE, 0, 2, 1, 32'hCAFE_F00D);
        run_op(OP_LH,  32'h1000_0006, 32'h0, EXC_NONE, 1, 0, -1, 32'h0);

        // Reset while a request is outstanding must clear the bus without a clock edge.
        @(negedge cpu_clk_50M);
        mem_valid_i = 1'b1; mem_aluop_i = OP_LW; mem_addr_i = 32'h2000_0004;
        mem_exccode_i = EXC_NONE; flush_i = 1'b0; bus.dbus_ack_i = 1'b0;
        @(negedge cpu_clk_50M);
        #1;
        chk("rst_pre_req", 32'(bus.dbus_req_o), 32'h1);
        cpu_rst = 1'b1; mem_valid_i = 1'b0;
        #1;
        check_reset_outputs("midreq");
        @(negedge cpu_clk_50M);
        cpu_rst = 1'b0;

        for (int i = 0; i < 120; i++) begin
            logic [7:0] op = op_tab[$urandom_range(0, 8)];
            int nw = $urandom_range(0, 4);
            int fa = ($urandom_range(0, 6) == 0) ? $urandom_range(0, nw) : -1;
            run_op(op, $urandom, $urandom,
                   ($urandom_range(0, 9) == 0) ? EXC_OV : EXC_NONE,
                   $urandom_range(0, 9) == 0, nw, fa, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage datapath for MiniMIPS32, directly downstream of the execute stage. It takes the load/store op, effective address and store data that execute produces and the EXE/MEM register holds, then checks alignment. It runs a request/acknowledge transaction on the data bus with correct byte enables, and returns sign- or zero-extended load data to the write-back path. While a transaction is outstanding it stalls the pipeline through `stallreq_mem`.

## Interface
- No parameters; widths come from `defines.v`.
- `cpu_clk_50M`  in  1  pipeline clock.
- `cpu_rst`  in  1  reset, asynchronous, active-high.
- `mem_valid_i`  in  1  an instruction occupies the MEM stage this cycle.
- `mem_aluop_i`  in  `ALUOP_BUS` (8)  internal opcode.
- `mem_addr_i`  in  32  effective address (execute `exe_wd_o`, registered).
- `mem_din_i`  in  32  store data (execute `exe_din_o`, registered).
- `mem_exccode_i`  in  `EXC_CODE_BUS`  exception code carried from earlier stages.
- `flush_i`  in  1  exception flush from the CP0/control unit.
- `dbus_req_o`  out  1  data-bus request, registered.
- `dbus_we_o`  out  1  1 = write.
- `dbus_addr_o`  out  32  word-aligned address, with bits [1:0] = 0.
- `dbus_be_o`  out  4  byte enables; lane n carries bits [8n+7:8n].
- `dbus_wdata_o`  out  32  lane-replicated store data.
- `dbus_ack_i`  in  1  transaction complete; read data is valid in the same cycle.
- `dbus_rdata_i`  in  32  read word.
- `load_data_o`  out  32  extended load result, registered.
- `load_valid_o`  out  1  one-cycle pulse when `load_data_o` is new.
- `mem_exccode_o`  out  `EXC_CODE_BUS`  exception code after the alignment check.
- `badvaddr_o`  out  32  faulting address. Equals `mem_addr_i` when an ADEL/ADES fault is raised, otherwise 0.
- `stallreq_mem`  out  1  stall request to the pipeline controller.

## Operation
- Memory ops are `MINIMIPS32_LB/LBU/LH/LHU/LW/SB/SH/SW`. All other aluops pass through untouched and start no transaction.
- Alignment check (combinational):
  - LW/SW require `addr[1:0]==0`.
  - LH/LHU/SH require `addr[0]==0`.
  - Byte ops are always aligned.
- Exception code output:
  - If `mem_exccode_i != EXC_NONE`, pass `mem_exccode_i` through unchanged; an earlier exception has priority.
  - Else a misaligned load gives `EXC_ADEL` and a misaligned store gives `EXC_ADES`.
  - Otherwise `EXC_NONE`.
- `start` = `mem_valid_i` & memory op & no incoming exception & aligned & !`flush_i`.
- FSM states: IDLE, REQ, DONE.
- **IDLE**
  - `stallreq_mem = start`, combinational.
  - On `start`, latch `dbus_*` at the clock edge and go to REQ.
  - `dbus_addr_o = {addr[31:2],2'b00}`; `dbus_we_o` = store.
- **Byte enables and write data** (little-endian):
  - SB: `be = 1<<addr[1:0]`, `wdata = {4{din[7:0]}}`.
  - SH: `be = addr[1] ? 4'b1100 : 4'b0011`, `wdata = {2{din[15:0]}}`.
  - SW: `be = 4'b1111`, `wdata = din`.
  - Loads: `be` is set as for the matching width; `wdata = 0`.
- **REQ**
  - `dbus_req_o=1`; `stallreq_mem=1`.
  - All `dbus_*` outputs are held stable until `dbus_ack_i`.
  - On ack, drop the request at the edge.
  - For a load, register the extracted lane into `load_data_o`:
    - LB/LBU: byte at lane `addr[1:0]`, sign- or zero-extended.
    - LH/LHU: halfword at `addr[1]`, sign- or zero-extended.
    - LW: the full word.
  - Next state is DONE, or IDLE if the op was flushed.
- **DONE**
  - `stallreq_mem=0`.
  - `load_valid_o=1` for a load (0 for a store).
  - Always return to IDLE next cycle; `start` is ignored in DONE, so the same instruction is never re-issued.
- **Flush**
  - `flush_i` in IDLE suppresses `start`.
  - `flush_i` in REQ does not withdraw the request. The bus transaction completes on ack, `load_valid_o` is suppressed, and the FSM goes to IDLE.
  - `stallreq_mem` stays 1 until ack.
- `dbus_ack_i` while `dbus_req_o=0` is ignored.
- **Reset**
  - State IDLE; `dbus_req_o`, `dbus_we_o`, `load_valid_o` = 0.
  - `dbus_addr_o`, `dbus_be_o`, `dbus_wdata_o`, `load_data_o` = 0.
  - Reset asserted mid-REQ drops `dbus_req_o` immediately, without waiting for a clock edge.

## Timing
- Zero-wait bus (ack in the first REQ cycle):
  - C0 IDLE, `start`, stall=1.
  - C1 REQ, req=1, ack=1.
  - C2 DONE, `load_valid_o=1`, stall=0.
  - The pipeline advances at the end of C2.
- Each wait cycle (req=1, ack=0) adds one stall cycle. Total stall = 2 + N wait cycles.
- `mem_exccode_o` and `badvaddr_o` are combinational from the current inputs with zero latency. Misaligned ops never stall.
- Back-to-back memory ops: the second op's `start` is evaluated in the IDLE cycle after DONE.

## Test plan
- **LW, zero-wait:** addr `0x1000_0008`, rdata `0xDEAD_BEEF`, ack in the first REQ cycle → `be=1111`, `load_data_o=0xDEADBEEF`, `load_valid_o` in C2, exactly 2 stall cycles.
- **LB / LBU sign handling:** addr `0x...0003`, rdata `0x80112233`.
  - LB → `be=1000`, `load_data_o=0xFFFFFF80`.
  - LBU → `load_data_o=0x00000080`.
- **SH, wait states:** addr `0x...0002`, din `0x0000ABCD`, ack after 3 wait cycles → `be=1100`, `wdata=0xABCDABCD`, `we=1`; outputs stable throughout REQ; 5 stall cycles; no `load_valid_o`.
- **Misaligned accesses:**
  - LW at `0x...0001` → `EXC_ADEL`, `badvaddr_o=0x...0001`, no `dbus_req_o`, no stall.
  - SW with incoming `EXC_OV` → `EXC_OV` passed through, no request.
- **Flush and reset mid-transaction:**
  - `flush_i` pulsed during REQ of an LW → request held until ack, then IDLE, no `load_valid_o`.
  - `cpu_rst` asserted mid-REQ → `dbus_req_o` low immediately, all outputs at reset values.
